imem_loader: RTL and testbench

- Write-side counterpart of the dual-port instruction/data ROM: accepts a framed byte stream (typically from UART RX) and writes 32-bit words into instruction memory through a single synchronous write port.
- `busy` holds the CPU in reset while a program image is being loaded.
- Sits between the serial receiver and the memory write port; the CPU read ports are unaffected.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction-memory word writer
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module imem_loader #(
  parameter int         ADDR_WIDTH     = 12,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("imem_loader: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, A_LO, A_HI, C_LO, C_HI, DATA, CHK, FIN} state_t;

  state_t                state;
  logic [7:0]            hdr_lo;
  logic [7:0]            chk_acc;
  logic [15:0]           words_left;
  logic [1:0]            byte_idx;
  logic [23:0]           word_sr;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  xfer;
  logic                  tmo_hit;
  logic [15:0]           hdr_word;

  assign xfer     = rx_valid && rx_ready;
  assign hdr_word = {rx_data, hdr_lo};

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts idle cycles inside a frame; any accepted byte restarts it.
  always_ff @(posedge clk) begin
    if (rst || xfer || state == IDLE || state == FIN) tmo_cnt <= '0;
    else                                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = !xfer && state != IDLE && state != FIN &&
                   tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      hdr_lo     <= '0;
      chk_acc    <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      addr       <= '0;
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      if (tmo_hit) begin
        state    <= FIN;
        rx_ready <= 1'b0;
        busy     <= 1'b0;
        error    <= 1'b1;
      end else begin
        case (state)
          IDLE: if (xfer && rx_data == SYNC_BYTE) begin
            state   <= A_LO;
            busy    <= 1'b1;
            chk_acc <= '0;
          end
          A_LO: if (xfer) begin
            hdr_lo  <= rx_data;
            chk_acc <= chk_acc ^ rx_data;
            state   <= A_HI;
          end
          A_HI: if (xfer) begin
            addr    <= hdr_word[ADDR_WIDTH-1:0];
            chk_acc <= chk_acc ^ rx_data;
            state   <= C_LO;
          end
          C_LO: if (xfer) begin
            hdr_lo  <= rx_data;
            chk_acc <= chk_acc ^ rx_data;
            state   <= C_HI;
          end
          C_HI: if (xfer) begin
            words_left <= hdr_word;
            byte_idx   <= '0;
            chk_acc    <= chk_acc ^ rx_data;
            state      <= (hdr_word == 16'd0) ? CHK : DATA;
          end
          DATA: if (xfer) begin
            chk_acc  <= chk_acc ^ rx_data;
            word_sr  <= {rx_data, word_sr[23:8]};
            byte_idx <= byte_idx + 2'd1;
            // Bytes arrive LSB first, so the 4th byte lands on top of the three held ones.
            if (byte_idx == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= addr;
              mem_wdata  <= {rx_data, word_sr};
              addr       <= addr + 1'b1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= CHK;
            end
          end
          CHK: if (xfer) begin
            done     <= (rx_data == chk_acc);
            error    <= (rx_data != chk_acc);
            busy     <= 1'b0;
            rx_ready <= 1'b0;
            state    <= FIN;
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Timeout steps run only when LOADER_TIMEOUT_EN is defined.
module tb_imem_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) wr_cnt++;
    if (done)   done_cnt++;
    if (error)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte is presented before rx_ready is seen, so a FIN-cycle hold is exercised.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_wdata",    mem_wdata,         32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // Good frame, two words at 0x100, checksum 0x8B
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    check("t1_busy_set", {31'd0, busy}, 32'd1);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1_no_we_early", {31'd0, mem_we}, 32'd0);
    send_byte(8'h44);
    check("t1_we0",    {31'd0, mem_we},   32'd1);
    check("t1_addr0",  {20'd0, mem_addr}, 32'h100);
    check("t1_data0",  mem_wdata,         32'h44332211);
    send_byte(8'h55);
    check("t1_we_drop",   {31'd0, mem_we},   32'd0);
    check("t1_addr_hold", {20'd0, mem_addr}, 32'h100);
    check("t1_data_hold", mem_wdata,         32'h44332211);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check("t1_we1",   {31'd0, mem_we},   32'd1);
    check("t1_addr1", {20'd0, mem_addr}, 32'h101);
    check("t1_data1", mem_wdata,         32'h88776655);
    send_byte(8'h8B);
    check("t1_done",     {31'd0, done},     32'd1);
    check("t1_error",    {31'd0, error},    32'd0);
    check("t1_busy_fin", {31'd0, busy},     32'd0);
    check("t1_ready_fin",{31'd0, rx_ready}, 32'd0);

    // Bad checksum; SYNC is presented during FIN and must be held, not lost
    send_byte(8'hA5);
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    check("t2_busy",         {31'd0, busy}, 32'd1);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("t2_we0",   {31'd0, mem_we},   32'd1);
    check("t2_addr0", {20'd0, mem_addr}, 32'h100);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check("t2_we1",   {31'd0, mem_we},   32'd1);
    check("t2_data1", mem_wdata,         32'h88776655);
    send_byte(8'h04);
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_done",  {31'd0, done},  32'd0);
    check("t2_busy",  {31'd0, busy},  32'd0);
    @(negedge clk);
    check("t2_error_pulse", {31'd0, error}, 32'd0);

    // Garbage then zero-length frame
    send_byte(8'h00);
    check("t3_busy_g0", {31'd0, busy}, 32'd0);
    send_byte(8'hFF);
    check("t3_busy_g1", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    check("t3_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check("t3_done", {31'd0, done}, 32'd1);
    #1;
    check("t3_wr_cnt", wr_cnt, 32'd4);

    // Address wrap at 0xFFF
    send_byte(8'hA5);
    send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("t4_addr0", {20'd0, mem_addr}, 32'hFFF);
    check("t4_data0", mem_wdata,         32'h04030201);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    check("t4_we1",   {31'd0, mem_we},   32'd1);
    check("t4_addr1", {20'd0, mem_addr}, 32'h000);
    check("t4_data1", mem_wdata,         32'h08070605);
    send_byte(8'hFA);
    check("t4_done", {31'd0, done}, 32'd1);

    // Reset after two data bytes
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t5_busy",     {31'd0, busy},     32'd0);
    check("t5_mem_we",   {31'd0, mem_we},   32'd0);
    check("t5_addr",     {20'd0, mem_addr}, 32'd0);
    check("t5_wdata",    mem_wdata,         32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_back", {31'd0, rx_ready}, 32'd1);
    #1;
    check("t5_wr_cnt",   wr_cnt,   32'd6);
    check("t5_done_cnt", done_cnt, 32'd3);
    check("t5_err_cnt",  err_cnt,  32'd1);

    // Next frame after reset; upper address bits 0x1xxx are dropped
    send_byte(8'hA5);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("t6_we",   {31'd0, mem_we},   32'd1);
    check("t6_addr", {20'd0, mem_addr}, 32'h234);
    check("t6_data", mem_wdata,         32'hEFBEADDE);
    send_byte(8'h05);
    check("t6_done", {31'd0, done}, 32'd1);

`ifdef LOADER_TIMEOUT_EN
    // Header only, then silence
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    repeat (15) @(negedge clk);
    check("t7_no_error_yet", {31'd0, error}, 32'd0);
    check("t7_busy_wait",    {31'd0, busy},  32'd1);
    @(negedge clk);
    check("t7_error", {31'd0, error}, 32'd1);
    check("t7_done",  {31'd0, done},  32'd0);
    check("t7_busy",  {31'd0, busy},  32'd0);
    @(negedge clk);
    check("t7_error_pulse", {31'd0, error}, 32'd0);
`endif

    @(negedge clk);
    #1;
    check("end_wr_cnt",   wr_cnt,   32'd7);
    check("end_done_cnt", done_cnt, 32'd4);
`ifdef LOADER_TIMEOUT_EN
    check("end_err_cnt", err_cnt, 32'd2);
`else
    check("end_err_cnt", err_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
